// File: rtl/div32_seq_pkg.sv
// Shared definitions for the iterative restoring divider: widths, FSM
// state encodings and the quotient reported for a zero divisor.
package div32_seq_pkg;

   // Operand / result width and iteration counter width.
   // The counter must be able to hold WIDTH-1, i.e. 2**DIV_CNT_W > DIV_WIDTH.
   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   // Quotient reported when the divisor is zero.
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

endpackage : div32_seq_pkg

// File: rtl/div32_seq_if.sv
// Start/done handshake between the ALU controller (master) and the
// divide unit (slave).
interface div32_seq_if
   import div32_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);

   logic             op_start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_busy;
   logic             op_done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output op_start, op_a, op_b,
      input  op_busy, op_done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  op_start, op_a, op_b,
      output op_busy, op_done, quotient, remainder, div_by_zero
   );

endinterface : div32_seq_if

// File: rtl/div32_seq_sub_borrow.sv
// sub_borrow: combinational N-bit subtractor a - b computed as a + ~b + 1
// on 4-bit carry-lookahead groups. borrow_o is the inverted carry-out.
module div32_seq_sub_borrow #(
   parameter int N = 33
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] diff_o,
   output logic         borrow_o
);

   // Operands are padded to a whole number of 4-bit lookahead groups.
   localparam int NG = (N + 3) / 4;
   localparam int NP = NG * 4;

   logic [NP-1:0] a_ext;
   logic [NP-1:0] b_inv;
   logic [NP-1:0] gen;
   logic [NP-1:0] prop;
   logic [NP:0]   carry;
   logic          pad_unused;

   // Generate/propagate terms and group carry-lookahead, carry-in of 1 for +1.
   always_comb begin
      // NOTE: every variable gets a default before any conditional or partial
      // update so no latch can be inferred in combinational logic.
      a_ext          = '0;
      a_ext[N-1:0]   = a_i;
      b_inv          = '1;
      b_inv[N-1:0]   = ~b_i;
      gen            = a_ext & b_inv;
      prop           = a_ext ^ b_inv;
      carry          = '0;
      carry[0]       = 1'b1;
      for (int k = 0; k < NG; k++) begin
         carry[4*k+1] = gen[4*k]
                      | (prop[4*k] & carry[4*k]);
         carry[4*k+2] = gen[4*k+1]
                      | (prop[4*k+1] & gen[4*k])
                      | (prop[4*k+1] & prop[4*k] & carry[4*k]);
         carry[4*k+3] = gen[4*k+2]
                      | (prop[4*k+2] & gen[4*k+1])
                      | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                      | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
         carry[4*k+4] = gen[4*k+3]
                      | (prop[4*k+3] & gen[4*k+2])
                      | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                      | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k])
                      | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
      end
   end

   assign diff_o   = prop[N-1:0] ^ carry[N-1:0];
   assign borrow_o = ~carry[N];

   // Padding bits above N only feed the lookahead chain.
   assign pad_unused = ^{a_ext, b_inv, gen, prop, carry};

endmodule : div32_seq_sub_borrow

// File: rtl/div32_seq.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Holds the FSM, iteration counter and R/Q/B registers; the trial
// subtraction lives in the sub_borrow subtractor.
module div32_seq
   import div32_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic      clk,
   input  logic      reset_n,
   div32_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;
   logic             done_q;
   logic             busy_q;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] q_d;
   logic             diff_unused;

   // {R,Q} shifted left by one: the partial remainder picks up the next dividend bit.
   assign r_shift = {r_q, q_q[WIDTH-1]};

   div32_seq_sub_borrow #(
      .N (WIDTH + 1)
   ) u_sub_borrow (
      .a_i      (r_shift),
      .b_i      ({1'b0, b_q}),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   // Restore step: keep the shifted remainder on borrow, else take the difference.
   always_comb begin
      r_d = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], ~borrow};
   end

   // A difference without borrow is below B, so its top bit is always zero.
   assign diff_unused = diff[WIDTH];

   // Control FSM, datapath registers and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         r_q         <= '0;
         q_q         <= '0;
         b_q         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.op_start) begin
                  b_q    <= bus.op_b;
                  r_q    <= '0;
                  q_q    <= bus.op_a;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (bus.op_b == '0) begin
                     quotient_q  <= WIDTH'(DIV0_QUOT);
                     remainder_q <= bus.op_a;
                     dbz_q       <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     dbz_q   <= 1'b0;
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  quotient_q  <= q_d;
                  remainder_q <= r_d;
                  done_q      <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.op_busy     = busy_q;
   assign bus.op_done     = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule : div32_seq

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vector table, hand-written
// corner sequences (ignored start, mid-operation reset) and a short
// random sweep checked against the language / and % operators.
module tb_div32_seq;

   logic clk;
   logic reset_n;

   div32_seq_if bus ();

   div32_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present an operation for one edge; busy must be high right after acceptance.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input string name);
      @(posedge clk); #1;
      bus.op_start = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      @(posedge clk); #1;
      bus.op_start = 1'b0;
      check({name, " busy after start"}, 64'(bus.op_busy), 64'd1);
   endtask

   // Count edges (after the acceptance edge) until op_done is seen; bounded.
   task automatic wait_done(input int start_cnt, output int lat);
      lat = start_cnt;
      while (!bus.op_done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Full operation: latency in cycles (acceptance edge N -> done in cycle N+lat),
   // results, then a one-cycle done pulse and return to idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat, input string name);
      int lat;
      start_op(a, b, name);
      wait_done(0, lat);
      check({name, " latency"}, 64'(lat + 1), 64'(elat));
      check({name, " quotient"}, 64'(bus.quotient), 64'(eq));
      check({name, " remainder"}, 64'(bus.remainder), 64'(er));
      check({name, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edbz));
      @(posedge clk); #1;
      check({name, " done pulse width"}, 64'(bus.op_done), 64'd0);
      check({name, " busy cleared"}, 64'(bus.op_busy), 64'd0);
   endtask

   vec_t vecs[11];

   initial begin
      int lat;
      int done_seen;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,     dbz: 1'b0, lat: 33};
      vecs[1]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,     dbz: 1'b0, lat: 33};
      vecs[2]  = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,     dbz: 1'b0, lat: 33};
      vecs[3]  = '{a: 32'd5,          b: 32'd10,         q: 32'd0,          r: 32'd5,     dbz: 1'b0, lat: 33};
      vecs[4]  = '{a: 32'd0,          b: 32'd3,          q: 32'd0,          r: 32'd0,     dbz: 1'b0, lat: 33};
      vecs[5]  = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234,  dbz: 1'b1, lat: 1};
      vecs[6]  = '{a: 32'd9,          b: 32'd3,          q: 32'd3,          r: 32'd0,     dbz: 1'b0, lat: 33};
      vecs[7]  = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'd715827882,  r: 32'd2,     dbz: 1'b0, lat: 33};
      vecs[8]  = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,     dbz: 1'b1, lat: 1};
      vecs[9]  = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,     dbz: 1'b0, lat: 33};
      vecs[10] = '{a: 32'h1234_5678,  b: 32'h0000_1000,  q: 32'h0001_2345,  r: 32'h678,   dbz: 1'b0, lat: 33};

      bus.op_start = 1'b0;
      bus.op_a     = '0;
      bus.op_b     = '0;
      reset_n      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(bus.op_busy), 64'd0);
      check("reset done", 64'(bus.op_done), 64'd0);
      check("reset quotient", 64'(bus.quotient), 64'd0);
      check("reset remainder", 64'(bus.remainder), 64'd0);
      check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
      reset_n = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat,
                $sformatf("vec%0d", i));
      end

      // Start pulse during RUN is ignored; operand changes after acceptance do not matter.
      start_op(32'd1000, 32'd3, "ignore");
      repeat (9) begin
         @(posedge clk); #1;
      end
      bus.op_start = 1'b1;
      bus.op_a     = 32'd8;
      bus.op_b     = 32'd2;
      @(posedge clk); #1;
      bus.op_start = 1'b0;
      bus.op_a     = 32'hDEAD_BEEF;
      bus.op_b     = 32'd0;
      wait_done(10, lat);
      check("ignore latency", 64'(lat + 1), 64'd33);
      check("ignore quotient", 64'(bus.quotient), 64'd333);
      check("ignore remainder", 64'(bus.remainder), 64'd1);
      @(posedge clk); #1;
      check("ignore no second op", 64'(bus.op_busy), 64'd0);

      // Reset in the middle of an operation abandons it without a done pulse.
      start_op(32'd1000, 32'd3, "midreset");
      repeat (13) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("midreset busy", 64'(bus.op_busy), 64'd0);
      check("midreset done", 64'(bus.op_done), 64'd0);
      check("midreset quotient", 64'(bus.quotient), 64'd0);
      check("midreset remainder", 64'(bus.remainder), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.op_done || bus.op_busy) done_seen++;
      end
      check("midreset stays idle", 64'(done_seen), 64'd0);
      run_op(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, "after reset");

      // Short random sweep against the behavioural operators.
      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if (rb == 32'd0) rb = 32'd1;
         run_op(ra, rb, ra / rb, ra % rb, 1'b0, 33, $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_div32_seq
